// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing controller: phase encoding,
// configuration selector codes and the 640x480 default timing.
package vga_timing_pkg;

  // Width of every length register and of the per-axis counters.
  localparam int LEN_W   = 10;
  localparam int NUM_SEL = 8;

  // Order in which each axis walks through a line/frame.
  typedef enum logic [1:0] {
    FRONT_PORCH = 2'd0,
    SYNC        = 2'd1,
    BACK_PORCH  = 2'd2,
    ACTIVE      = 2'd3
  } phase_e;

  // Configuration register selectors.
  localparam logic [2:0] SEL_H_FP = 3'd0;
  localparam logic [2:0] SEL_H_SP = 3'd1;
  localparam logic [2:0] SEL_H_BP = 3'd2;
  localparam logic [2:0] SEL_H_AV = 3'd3;
  localparam logic [2:0] SEL_V_FP = 3'd4;
  localparam logic [2:0] SEL_V_SP = 3'd5;
  localparam logic [2:0] SEL_V_BP = 3'd6;
  localparam logic [2:0] SEL_V_AV = 3'd7;

  // 640x480 @ 60 Hz defaults.
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SP = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_H_AV = 640;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SP = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_V_AV = 480;

  // A zero length would stall an axis forever, so it is refused. The
  // active-length upper bound of 1023 is the full range of the 10-bit
  // data bus, so no wider value can ever arrive to be refused.
  function automatic logic cfg_data_ok(input logic [LEN_W-1:0] data);
    return data != '0;
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One timing axis: phase state plus a phase counter that advances on adv_i
// and moves to the next phase when the count reaches the phase length - 1.
module timing_axis
  import vga_timing_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv_i,
  input  logic [LEN_W-1:0] len_fp_i,
  input  logic [LEN_W-1:0] len_sp_i,
  input  logic [LEN_W-1:0] len_bp_i,
  input  logic [LEN_W-1:0] len_av_i,
  output logic [1:0]       phase_o,
  output logic [LEN_W-1:0] count_o,
  output logic             last_o
);

  phase_e           phase_q, phase_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_cur;

  // Select the length of the phase currently being counted.
  always_comb begin
    len_cur = len_fp_i;
    unique case (phase_q)
      FRONT_PORCH: len_cur = len_fp_i;
      SYNC:        len_cur = len_sp_i;
      BACK_PORCH:  len_cur = len_bp_i;
      ACTIVE:      len_cur = len_av_i;
      default:     len_cur = len_fp_i;
    endcase
  end

  assign last_o = (count_q == len_cur - LEN_W'(1));

  // Advance the counter; on the last count wrap to 0 and step the phase.
  always_comb begin
    phase_d = phase_q;
    count_d = count_q;
    if (adv_i) begin
      if (last_o) begin
        count_d = '0;
        unique case (phase_q)
          FRONT_PORCH: phase_d = SYNC;
          SYNC:        phase_d = BACK_PORCH;
          BACK_PORCH:  phase_d = ACTIVE;
          ACTIVE:      phase_d = FRONT_PORCH;
          default:     phase_d = FRONT_PORCH;
        endcase
      end else begin
        count_d = count_q + LEN_W'(1);
      end
    end
  end

  // Phase and counter state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= FRONT_PORCH;
      count_q <= '0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  assign phase_o = phase_q;
  assign count_o = count_q;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA timing generator with a run-time reconfigurable timing set. Writes
// land in pending registers; an armed commit copies them into the active
// registers only at frame end so a frame is never torn.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int H_FP = DEF_H_FP,
  parameter int H_SP = DEF_H_SP,
  parameter int H_BP = DEF_H_BP,
  parameter int H_AV = DEF_H_AV,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SP = DEF_V_SP,
  parameter int V_BP = DEF_V_BP,
  parameter int V_AV = DEF_V_AV
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_valid_i,
  output logic       cfg_ready_o,
  input  logic [2:0] cfg_sel_i,
  input  logic [9:0] cfg_data_i,
  input  logic       cfg_commit_i,
  output logic       cfg_err_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       active_video_o,
  output logic [9:0] pixel_x_o,
  output logic [9:0] pixel_y_o,
  output logic       line_start_o,
  output logic       frame_start_o
);

  localparam logic [LEN_W-1:0] LEN_RST [NUM_SEL] = '{
    LEN_W'(H_FP), LEN_W'(H_SP), LEN_W'(H_BP), LEN_W'(H_AV),
    LEN_W'(V_FP), LEN_W'(V_SP), LEN_W'(V_BP), LEN_W'(V_AV)
  };

  logic [LEN_W-1:0] pend_q [NUM_SEL];
  logic [LEN_W-1:0] pend_d [NUM_SEL];
  logic [LEN_W-1:0] act_q  [NUM_SEL];
  logic [LEN_W-1:0] act_d  [NUM_SEL];
  logic             armed_q, armed_d;
  logic             err_q, err_d;

  logic [1:0]       h_phase, v_phase;
  logic [LEN_W-1:0] h_count, v_count;
  logic             h_last, v_last;
  logic             h_line_end, frame_end, wr_accept;

  timing_axis u_h_axis (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .adv_i    (1'b1),
    .len_fp_i (act_q[SEL_H_FP]),
    .len_sp_i (act_q[SEL_H_SP]),
    .len_bp_i (act_q[SEL_H_BP]),
    .len_av_i (act_q[SEL_H_AV]),
    .phase_o  (h_phase),
    .count_o  (h_count),
    .last_o   (h_last)
  );

  timing_axis u_v_axis (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .adv_i    (h_line_end),
    .len_fp_i (act_q[SEL_V_FP]),
    .len_sp_i (act_q[SEL_V_SP]),
    .len_bp_i (act_q[SEL_V_BP]),
    .len_av_i (act_q[SEL_V_AV]),
    .phase_o  (v_phase),
    .count_o  (v_count),
    .last_o   (v_last)
  );

  assign h_line_end = (h_phase == ACTIVE) && h_last;
  assign frame_end  = h_line_end && (v_phase == ACTIVE) && v_last;
  assign wr_accept  = cfg_valid_i && cfg_ready_o;

  // Configuration: accept/reject writes, arm commits, apply at frame end.
  // The write is evaluated before the arm so a same-cycle write is included.
  always_comb begin
    pend_d  = pend_q;
    act_d   = act_q;
    armed_d = armed_q;
    err_d   = 1'b0;
    if (wr_accept) begin
      if (cfg_data_ok(cfg_data_i)) begin
        pend_d[cfg_sel_i] = cfg_data_i;
      end else begin
        err_d = 1'b1;
      end
    end
    if (cfg_commit_i && !armed_q) begin
      armed_d = 1'b1;
    end
    if (armed_q && frame_end) begin
      act_d   = pend_q;
      armed_d = 1'b0;
    end
  end

  // Configuration state registers; reset discards pending writes and commits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= LEN_RST;
      act_q   <= LEN_RST;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      act_q   <= act_d;
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  // Moore output decode straight from the state registers.
  assign cfg_ready_o    = !armed_q;
  assign cfg_err_o      = err_q;
  assign hsync_o        = (h_phase != SYNC);
  assign vsync_o        = (v_phase != SYNC);
  assign active_video_o = (h_phase == ACTIVE) && (v_phase == ACTIVE);
  assign pixel_x_o      = (h_phase == ACTIVE) ? h_count : '0;
  assign pixel_y_o      = (v_phase == ACTIVE) ? v_count : '0;
  assign line_start_o   = (h_phase == ACTIVE) && (h_count == '0);
  assign frame_start_o  = line_start_o && (v_phase == ACTIVE) && (v_count == '0);

endmodule

// File: tb/tb_vga_timing_controller.sv
// Scoreboard bench for vga_timing_controller using a scaled-down timing set
// (line = 3+4+2+8 = 17 clocks, frame = 2+1+2+4 = 9 lines = 153 clocks).
module tb_vga_timing_controller;

  localparam int HFP = 3, HSP = 4, HBP = 2, HAV = 8;
  localparam int VFP = 2, VSP = 1, VBP = 2, VAV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_sel = '0;
  logic [9:0] cfg_data = '0;
  logic       cfg_commit = 1'b0;
  logic       cfg_ready, cfg_err, hsync, vsync, active_video;
  logic [9:0] pixel_x, pixel_y;
  logic       line_start, frame_start;

  always #5 clk = ~clk;

  vga_timing_controller #(
    .H_FP(HFP), .H_SP(HSP), .H_BP(HBP), .H_AV(HAV),
    .V_FP(VFP), .V_SP(VSP), .V_BP(VBP), .V_AV(VAV)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .cfg_sel_i      (cfg_sel),
    .cfg_data_i     (cfg_data),
    .cfg_commit_i   (cfg_commit),
    .cfg_err_o      (cfg_err),
    .hsync_o        (hsync),
    .vsync_o        (vsync),
    .active_video_o (active_video),
    .pixel_x_o      (pixel_x),
    .pixel_y_o      (pixel_y),
    .line_start_o   (line_start),
    .frame_start_o  (frame_start)
  );

  typedef struct {
    int period; int act; int maxx; int maxy; int lines; int vlow;
  } frame_t;

  // Windows run from one frame_start to the next.
  localparam frame_t F_DEF = '{153, 32, 7, 3, 9, 17};
  // Old 17-clock lines until frame end, then 14-clock lines (H_AV=5).
  localparam frame_t F_MIX = '{138, 32, 7, 3, 9, 14};
  localparam frame_t F_NEW = '{126, 20, 4, 3, 9, 14};
  // {hsync, vsync, active, px, py, line_start, frame_start, err, ready}
  localparam logic [26:0] RST_VEC = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};

  frame_t      frame_q[$];
  int          err_q[$];
  int          fall_q[$];
  int          rise_q[$];
  int          hs_start_q[$];
  int          hs_width_q[$];
  logic [26:0] rst_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  frame_t st;
  logic   in_frame = 1'b0;
  logic   prev_hs = 1'b1, prev_rdy = 1'b1, prev_act = 1'b0;
  int     prev_px = 0, prev_py = 0, hs_start = 0;
  frame_t f;

  always @(negedge clk) begin
    if (rst) begin
      if (rst_q.size() > 0) begin
        check("reset_outputs",
              int'({hsync, vsync, active_video, pixel_x, pixel_y, line_start,
                    frame_start, cfg_err, cfg_ready}), int'(rst_q.pop_front()));
        $display("reset check at cycle %0d", cyc);
      end
      cyc = 0; in_frame = 1'b0; prev_hs = 1'b1; prev_rdy = 1'b1;
      prev_act = 1'b0; prev_px = 0; prev_py = 0;
    end else begin
      if (frame_start) begin
        check("fs_position", int'({pixel_x, pixel_y, active_video}), 1);
        if (in_frame && frame_q.size() > 0) begin
          f = frame_q.pop_front();
          check("frame_period", st.period, f.period);
          check("frame_active", st.act, f.act);
          check("frame_max_x", st.maxx, f.maxx);
          check("frame_max_y", st.maxy, f.maxy);
          check("frame_lines", st.lines, f.lines);
          check("frame_vsync_low", st.vlow, f.vlow);
          $display("frame window: period=%0d active=%0d maxx=%0d maxy=%0d lines=%0d vlow=%0d",
                   st.period, st.act, st.maxx, st.maxy, st.lines, st.vlow);
        end
        in_frame = 1'b1;
        st = '{0, 0, 0, 0, 0, 0};
      end
      if (in_frame) begin
        st.period++;
        if (active_video) st.act++;
        if (int'(pixel_x) > st.maxx) st.maxx = int'(pixel_x);
        if (int'(pixel_y) > st.maxy) st.maxy = int'(pixel_y);
        if (line_start) st.lines++;
        if (!vsync) st.vlow++;
      end
      if (cfg_err) begin
        if (err_q.size() > 0) check("err_cycle", cyc, err_q.pop_front());
        else check("err_spurious", int'(cfg_err), 0);
        $display("cfg_err pulse at cycle %0d", cyc);
      end
      if (!cfg_ready && prev_rdy) begin
        if (fall_q.size() > 0) check("ready_fall_cycle", cyc, fall_q.pop_front());
        else check("ready_fall_spurious", int'(cfg_ready), 1);
        $display("cfg_ready fell at cycle %0d", cyc);
      end
      if (cfg_ready && !prev_rdy && rise_q.size() > 0) begin
        check("ready_rise_after", int'(prev_act) * 1048576 + prev_py * 1024 + prev_px,
              rise_q.pop_front());
        $display("cfg_ready rose at cycle %0d", cyc);
      end
      if (!hsync && prev_hs) hs_start = cyc;
      if (hsync && !prev_hs && hs_start_q.size() > 0) begin
        check("hsync_start", hs_start, hs_start_q.pop_front());
        check("hsync_width", cyc - hs_start, hs_width_q.pop_front());
        $display("hsync pulse start=%0d width=%0d", hs_start, cyc - hs_start);
      end
      prev_hs  = hsync;
      prev_rdy = cfg_ready;
      prev_act = active_video;
      prev_px  = int'(pixel_x);
      prev_py  = int'(pixel_y);
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One-cycle configuration transaction; c0 + 1 is the sample index at
  // which any registered response first becomes visible.
  task automatic drive(input logic v, input logic [2:0] sel, input logic [9:0] d,
                       input logic c, output int c0);
    @(posedge clk);
    #2;
    cfg_valid = v; cfg_sel = sel; cfg_data = d; cfg_commit = c;
    c0 = cyc;
    $display("drive valid=%0d sel=%0d data=%0d commit=%0d ready=%0d", v, sel, d, c, cfg_ready);
    @(posedge clk);
    #2;
    cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_data = '0; cfg_sel = '0;
  endtask

  task automatic wait_fs();
    logic found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (frame_start) found = 1'b1;
    end
    check("wait_frame_start", int'(found), 1);
  endtask

  task automatic wait_pos(input int x, input int y);
    logic found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (active_video && int'(pixel_x) == x && int'(pixel_y) == y) found = 1'b1;
    end
    check("wait_position", int'(found), 1);
  endtask

  int c0;

  initial begin
    rst_q.push_back(RST_VEC);
    tick(3);
    hs_start_q.push_back(HFP);
    hs_width_q.push_back(HSP);
    frame_q.push_back(F_DEF);
    frame_q.push_back(F_MIX);
    frame_q.push_back(F_NEW);
    frame_q.push_back(F_NEW);
    frame_q.push_back(F_NEW);
    rst = 1'b0;

    // Mid-frame H_AV=5 write together with commit.
    wait_fs();
    wait_fs();
    tick(10);
    rise_q.push_back(1048576 + 3 * 1024 + 7);
    drive(1'b1, 3'd3, 10'd5, 1'b1, c0);
    fall_q.push_back(c0 + 1);

    // Zero-length write is refused with an error pulse.
    wait_fs();
    tick(5);
    drive(1'b1, 3'd5, 10'd0, 1'b0, c0);
    err_q.push_back(c0 + 1);

    // Arm a commit, then try writes and a second commit while armed.
    wait_fs();
    tick(3);
    rise_q.push_back(1048576 + 3 * 1024 + 4);
    drive(1'b0, 3'd0, 10'd0, 1'b1, c0);
    fall_q.push_back(c0 + 1);
    tick(2);
    drive(1'b1, 3'd3, 10'd9, 1'b0, c0);
    drive(1'b1, 3'd5, 10'd0, 1'b1, c0);

    // Arm a commit, then reset mid-line while armed.
    wait_fs();
    wait_fs();
    tick(3);
    drive(1'b1, 3'd3, 10'd7, 1'b1, c0);
    fall_q.push_back(c0 + 1);
    wait_pos(2, 1);
    #2;
    rst_q.push_back(RST_VEC);
    rst = 1'b1;
    tick(3);
    hs_start_q.push_back(HFP);
    hs_width_q.push_back(HSP);
    frame_q.push_back(F_DEF);
    frame_q.push_back(F_DEF);
    rst = 1'b0;

    wait_fs();
    wait_fs();
    wait_fs();
    tick(2);
    check("frames_left", frame_q.size(), 0);
    check("errs_left", err_q.size(), 0);
    check("ready_falls_left", fall_q.size(), 0);
    check("ready_rises_left", rise_q.size(), 0);
    check("hsync_left", hs_start_q.size(), 0);
    check("resets_left", rst_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 The block SHALL have parameter H_FP, default 16, meaning horizontal front-porch length in pixel clocks.
REQ-002 The block SHALL have parameter H_SP, default 96, meaning horizontal sync length in pixel clocks.
REQ-003 The block SHALL have parameter H_BP, default 48, meaning horizontal back-porch length in pixel clocks.
REQ-004 The block SHALL have parameter H_AV, default 640, meaning horizontal active length in pixel clocks.
REQ-005 The block SHALL have parameters V_FP, V_SP, V_BP and V_AV, defaults 10, 2, 33 and 480, meaning the vertical phase lengths in lines.
REQ-006 The block SHALL have the port clk_i, input, 1 bit: the pixel clock, and the only clock.
REQ-007 The block SHALL have the port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-008 The block SHALL have the ports cfg_valid_i (input, 1), cfg_ready_o (output, 1), cfg_sel_i (input, 3) and cfg_data_i (input, 10): the configuration write handshake.
REQ-009 The block SHALL have the port cfg_commit_i, input, 1 bit: a pulse that arms the commit of the pending configuration.
REQ-010 The block SHALL have the port cfg_err_o, output, 1 bit: a one-cycle pulse flagging a rejected configuration write.
REQ-011 The block SHALL have the ports hsync_o and vsync_o, outputs, 1 bit each: active-low sync outputs.
REQ-012 The block SHALL have the port active_video_o, output, 1 bit: high only when both axes are in the ACTIVE phase.
REQ-013 The block SHALL have the ports pixel_x_o and pixel_y_o, outputs, 10 bits each: the active-area coordinates.
REQ-014 The block SHALL have the ports line_start_o and frame_start_o, outputs, 1 bit each: single-cycle markers.

Function
REQ-015 Each axis SHALL cycle through the phases FRONT_PORCH -> SYNC -> BACK_PORCH -> ACTIVE -> FRONT_PORCH, with each phase lasting exactly its configured length N.
- Phase counter runs 0..N-1.
- The phase advances, and the counter clears, on the cycle where count == N-1.
REQ-016 The horizontal axis SHALL advance every clock.
REQ-017 The vertical axis SHALL advance only on the line-end cycle (horizontal ACTIVE with count == H_AV-1).
REQ-018 The block SHALL drive hsync_o=0 while the horizontal axis is in SYNC, and 1 otherwise; vsync_o SHALL behave the same way for the vertical axis.
REQ-019 All outputs SHALL be decoded from the current state registers with zero added latency (Moore).
REQ-020 The coordinate outputs SHALL follow these rules:
- pixel_x_o = horizontal count while horizontal ACTIVE, else 0.
- pixel_y_o = vertical count while vertical ACTIVE, else 0.
REQ-021 The start markers SHALL fire as follows:
- line_start_o: first cycle of horizontal ACTIVE.
- frame_start_o: first cycle of horizontal ACTIVE in vertical line 0 of vertical ACTIVE.
REQ-022 The block SHALL accept a configuration write when cfg_valid_i && cfg_ready_o, storing cfg_data_i into the pending register selected by cfg_sel_i.
- Selector encoding: 0..3 = H FP/SP/BP/AV, 4..7 = V FP/SP/BP/AV.
REQ-023 A write whose data is 0, or whose data for selector 3 or 7 exceeds 1023, SHALL be dropped and SHALL pulse cfg_err_o for one cycle.
REQ-024 cfg_commit_i SHALL arm a commit.
- cfg_ready_o SHALL be 0 from the cycle after the arm until the commit is applied.
- A cfg_commit_i received while already armed SHALL be ignored.
REQ-025 An armed commit SHALL copy all pending registers into the active registers on the frame-end cycle (line-end of the last vertical ACTIVE line).
- The new lengths take effect from the next cycle.
- cfg_ready_o SHALL return to 1 on that same next cycle.
REQ-026 The active lengths SHALL never change at any point other than the frame-end cycle.
REQ-027 If cfg_valid_i and cfg_commit_i are both asserted in the same accepted cycle, the write SHALL land before the arm.

Reset
REQ-028 While rst_i=1, the block SHALL hold the following values:
- Both axes in FRONT_PORCH with count 0.
- hsync_o=1, vsync_o=1, active_video_o=0.
- pixel_x_o=0, pixel_y_o=0, line_start_o=0, frame_start_o=0, cfg_err_o=0.
- cfg_ready_o=1, commit disarmed.
- Pending and active registers loaded with the parameter defaults.
REQ-029 Reset asserted mid-line or mid-commit SHALL discard all pending writes and any armed commit.

Structure
REQ-030 The shared package vga_timing_pkg SHALL hold:
- the phase encoding (FRONT_PORCH=0, SYNC=1, BACK_PORCH=2, ACTIVE=3);
- the cfg_sel codes;
- the 640x480 default constants.
REQ-031 One generic sub-module, timing_axis (phase state + counter + length inputs + advance enable), SHALL be instantiated twice, once for horizontal and once for vertical.

Verification
REQ-032 Defaults, after reset release: hsync_o falls at cycle 16 and stays low for 96 cycles; line period is 800; frame period is 420000; active_video_o is high for 307200 cycles per frame.
REQ-033 Write sel=3 data=320 mid-frame plus commit: the current frame keeps 800-cycle lines; the next frame has 480-cycle lines, pixel_x_o max 319, and cfg_ready_o low until the frame end.
REQ-034 Write sel=5 data=0: cfg_err_o pulses once, and the timing is unchanged over the following frame.
REQ-035 Write attempted while commit is armed (cfg_ready_o=0): no acceptance, and the pending value is unchanged after the commit.
REQ-036 rst_i asserted at pixel_x_o=200, pixel_y_o=100 with a commit armed: outputs at their reset values immediately; after release, default 640x480 timing restarts from FRONT_PORCH.
REQ-037 frame_start_o pulses exactly once per frame, coincident with pixel_x_o=0, pixel_y_o=0, active_video_o=1.
